// File: rtl/cnt10_key_ctrl_pkg.sv
// Shared types for the cnt10 front-panel key controller.
package cnt10_key_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_LOCK
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_ADD1,
    STEP_ADD10,
    STEP_SUB1,
    STEP_SUB10
  } step_t;

endpackage

// File: rtl/cnt10_step_sel.sv
// Chooses the step command for one key decision, keeping the counter
// inside 0..UBND.
module cnt10_step_sel
  import cnt10_key_ctrl_pkg::*;
(
  input  dir_t             i_dir,
  input  logic             i_fast,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_ubnd,
  output step_t            o_step
);

  logic [CNT_W:0] w_cnt_p10;
  logic [CNT_W:0] w_ubnd_ext;

  assign w_cnt_p10  = {1'b0, i_cnt} + (CNT_W+1)'(10);
  assign w_ubnd_ext = {1'b0, i_ubnd};

  // Nine-bit sums keep CNT+10 from wrapping; a counter already above a
  // lowered bound gets no up step at all.
  always_comb begin
    o_step = STEP_NONE;
    if (i_dir == DIR_UP) begin
      if (i_fast && (w_cnt_p10 <= w_ubnd_ext)) begin
        o_step = STEP_ADD10;
      end else if (i_cnt < i_ubnd) begin
        o_step = STEP_ADD1;
      end
    end else begin
      if (i_fast && (i_cnt >= CNT_W'(10))) begin
        o_step = STEP_SUB10;
      end else if (i_cnt >= CNT_W'(1)) begin
        o_step = STEP_SUB1;
      end
    end
  end

endmodule

// File: rtl/cnt10_key_ctrl.sv
// Turns debounced up/down key levels into single-cycle cnt10 step
// commands with auto-repeat and x10 acceleration.
module cnt10_key_ctrl
  import cnt10_key_ctrl_pkg::*;
#(
  parameter int TW    = 25,
  parameter int DELAY = 25000000,
  parameter int RATE  = 5000000,
  parameter int ACCEL = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_key_up,
  input  logic             i_key_dn,
  input  logic [CNT_W-1:0] i_ubnd,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_add1,
  output logic             o_add10,
  output logic             o_sub1,
  output logic             o_sub10,
  output logic             o_clr,
  output logic             o_fast
);

  state_t        r_state;
  dir_t          r_dir;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_rep_cnt;

  dir_t          w_sel_dir;
  step_t         w_step;
  logic          w_key_held;
  logic [8:0]    w_rep_inc;

  assign w_sel_dir  = (r_state == ST_IDLE) ? (i_key_up ? DIR_UP : DIR_DN) : r_dir;
  assign w_key_held = (r_dir == DIR_UP) ? i_key_up : i_key_dn;
  assign w_rep_inc  = {1'b0, r_rep_cnt} + 9'd1;

  cnt10_step_sel u_step_sel (
    .i_dir  (w_sel_dir),
    .i_fast (o_fast),
    .i_cnt  (i_cnt),
    .i_ubnd (i_ubnd),
    .o_step (w_step)
  );

  // Key sequencer: press, hold delay, repeat cadence, clear-and-lock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_LOCK;
      r_dir     <= DIR_UP;
      r_timer   <= '0;
      r_rep_cnt <= '0;
      o_add1    <= 1'b0;
      o_add10   <= 1'b0;
      o_sub1    <= 1'b0;
      o_sub10   <= 1'b0;
      o_clr     <= 1'b0;
      o_fast    <= 1'b0;
    end else begin
      o_add1  <= 1'b0;
      o_add10 <= 1'b0;
      o_sub1  <= 1'b0;
      o_sub10 <= 1'b0;
      o_clr   <= 1'b0;
      if (r_state == ST_LOCK) begin
        if (!i_key_up && !i_key_dn) begin
          r_state <= ST_IDLE;
        end
      end else if (i_key_up && i_key_dn) begin
        o_clr     <= 1'b1;
        r_state   <= ST_LOCK;
        r_timer   <= '0;
        r_rep_cnt <= '0;
        o_fast    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_key_up ^ i_key_dn) begin
              o_add1  <= (w_step == STEP_ADD1);
              o_add10 <= (w_step == STEP_ADD10);
              o_sub1  <= (w_step == STEP_SUB1);
              o_sub10 <= (w_step == STEP_SUB10);
              r_timer <= TW'(DELAY);
              r_dir   <= w_sel_dir;
              r_state <= ST_HOLD;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (!w_key_held) begin
              r_state   <= ST_IDLE;
              r_timer   <= '0;
              r_rep_cnt <= '0;
              o_fast    <= 1'b0;
            end else if (r_timer == TW'(1)) begin
              o_add1  <= (w_step == STEP_ADD1);
              o_add10 <= (w_step == STEP_ADD10);
              o_sub1  <= (w_step == STEP_SUB1);
              o_sub10 <= (w_step == STEP_SUB10);
              r_timer <= TW'(RATE);
              r_state <= ST_REPEAT;
              if (r_rep_cnt < 8'(ACCEL)) begin
                r_rep_cnt <= w_rep_inc[7:0];
              end
              o_fast <= (w_rep_inc >= 9'(ACCEL));
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
          default: begin
            r_state <= ST_LOCK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnt10_key_ctrl.sv
// Self-checking bench for cnt10_key_ctrl and its step selector.
module tb_cnt10_key_ctrl;
  import cnt10_key_ctrl_pkg::*;

  localparam int TW    = 25;
  localparam int DELAY = 8;
  localparam int RATE  = 4;
  localparam int ACCEL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyUp;
  logic       keyDn;
  logic [7:0] ubnd;
  logic [7:0] cnt;
  logic       add1, add10, sub1, sub10, clr, fast;

  dir_t       selDir;
  logic       selFast;
  logic [7:0] selCnt;
  logic [7:0] selUbnd;
  step_t      selStep;

  int checks = 0;
  int passes = 0;

  bit    mLocked;
  bit    mPressed;
  bit    mDirUp;
  int    mAge;
  int    mReps;
  step_t expStep;
  bit    expClr;
  bit    expFast;
  int    cntNext;
  int    ubndNext;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  cnt10_key_ctrl #(
    .TW    (TW),
    .DELAY (DELAY),
    .RATE  (RATE),
    .ACCEL (ACCEL)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_key_up (keyUp),
    .i_key_dn (keyDn),
    .i_ubnd   (ubnd),
    .i_cnt    (cnt),
    .o_add1   (add1),
    .o_add10  (add10),
    .o_sub1   (sub1),
    .o_sub10  (sub10),
    .o_clr    (clr),
    .o_fast   (fast)
  );

  cnt10_step_sel uStepSel (
    .i_dir  (selDir),
    .i_fast (selFast),
    .i_cnt  (selCnt),
    .i_ubnd (selUbnd),
    .o_step (selStep)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Step rule straight from the front-panel description.
  function automatic step_t refStep(bit isUp, bit isFast, int c, int u);
    if (isUp) begin
      if (isFast && (c + 10 <= u)) return STEP_ADD10;
      if (c < u) return STEP_ADD1;
      return STEP_NONE;
    end
    if (isFast && c >= 10) return STEP_SUB10;
    if (c >= 1) return STEP_SUB1;
    return STEP_NONE;
  endfunction

  // Reference model: time since press decides when steps are due.
  task automatic modelAdvance();
    step_t s;
    bit    c;
    s = STEP_NONE;
    c = 1'b0;
    if (mLocked) begin
      if (!keyUp && !keyDn) mLocked = 1'b0;
    end else if (keyUp && keyDn) begin
      c        = 1'b1;
      mLocked  = 1'b1;
      mPressed = 1'b0;
      mReps    = 0;
    end else if (!mPressed) begin
      if (keyUp != keyDn) begin
        mPressed = 1'b1;
        mDirUp   = keyUp;
        mAge     = 0;
        s        = refStep(keyUp, 1'b0, int'(cnt), int'(ubnd));
      end
    end else if (!(mDirUp ? keyUp : keyDn)) begin
      mPressed = 1'b0;
      mReps    = 0;
    end else begin
      mAge++;
      if (mAge >= DELAY && ((mAge - DELAY) % RATE) == 0) begin
        s = refStep(mDirUp, mReps >= ACCEL, int'(cnt), int'(ubnd));
        mReps++;
      end
    end
    expStep = s;
    expClr  = c;
    expFast = mPressed && (mReps >= ACCEL);
  endtask

  task automatic runCycle(input bit up, input bit dn);
    @(negedge clk);
    checkOutput("add1",  add1,  expStep == STEP_ADD1);
    checkOutput("add10", add10, expStep == STEP_ADD10);
    checkOutput("sub1",  sub1,  expStep == STEP_SUB1);
    checkOutput("sub10", sub10, expStep == STEP_SUB10);
    checkOutput("clr",   clr,   expClr);
    checkOutput("fast",  fast,  expFast);
    cnt  = 8'(cntNext);
    ubnd = 8'(ubndNext);
    case (expStep)
      STEP_ADD1:  cntNext = int'(cnt) + 1;
      STEP_ADD10: cntNext = int'(cnt) + 10;
      STEP_SUB1:  cntNext = int'(cnt) - 1;
      STEP_SUB10: cntNext = int'(cnt) - 10;
      default:    cntNext = int'(cnt);
    endcase
    if (expClr) cntNext = 0;
    keyUp = up;
    keyDn = dn;
    modelAdvance();
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) runCycle(up, dn);
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncResetOutputs", {26'd0, add1, add10, sub1, sub10, clr, fast}, 32'd0);
    mLocked  = 1'b1;
    mPressed = 1'b0;
    mReps    = 0;
    expStep  = STEP_NONE;
    expClr   = 1'b0;
    expFast  = 1'b0;
    cntNext  = int'(cnt);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelAdvance();
  endtask

  initial begin
    int sc[8];
    int su[8];
    rst      = 1'b1;
    keyUp    = 1'b1;
    keyDn    = 1'b0;
    cnt      = 8'd5;
    cntNext  = 5;
    ubnd     = 8'd100;
    ubndNext = 100;
    mLocked  = 1'b1;
    mPressed = 1'b0;
    mDirUp   = 1'b1;
    mAge     = 0;
    mReps    = 0;
    expStep  = STEP_NONE;
    expClr   = 1'b0;
    expFast  = 1'b0;

    sc = '{0, 1, 10, 9, 90, 91, 245, 255};
    su = '{0, 0, 20, 19, 100, 100, 255, 200};
    for (int i = 0; i < 64; i++) begin
      for (int f = 0; f < 4; f++) begin
        selDir  = f[0] ? DIR_DN : DIR_UP;
        selFast = f[1];
        if (i < 8) begin
          selCnt  = 8'(sc[i]);
          selUbnd = 8'(su[i]);
        end else begin
          selCnt  = 8'($urandom_range(0, 255));
          selUbnd = 8'($urandom_range(0, 255));
        end
        #1;
        checkOutput("stepSel", 32'(selStep),
                    32'(refStep(selDir == DIR_UP, selFast, int'(selCnt), int'(selUbnd))));
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {26'd0, add1, add10, sub1, sub10, clr, fast}, 32'd0);
    rst = 1'b0;
    modelAdvance();

    applyStimulus(1, 0, 4);
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 40);
    applyStimulus(0, 0, 3);

    cntNext = 40;
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 60);
    applyStimulus(0, 0, 2);

    cntNext = 95;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 30);
    ubndNext = 90;
    applyStimulus(1, 0, 20);
    applyStimulus(0, 0, 2);

    ubndNext = 100;
    cntNext  = 30;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 10);
    applyStimulus(1, 1, 4);
    applyStimulus(1, 0, 3);
    applyStimulus(0, 0, 2);
    applyStimulus(1, 0, 12);
    applyStimulus(0, 0, 2);

    ubndNext = 200;
    cntNext  = 50;
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 30);
    pulseReset();
    applyStimulus(1, 0, 4);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 12);
    applyStimulus(0, 0, 2);

    for (int seg = 0; seg < 30; seg++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 45);
      if ($urandom_range(0, 3) == 0) ubndNext = $urandom_range(0, 255);
      if ($urandom_range(0, 4) == 0) cntNext = $urandom_range(0, 255);
      applyStimulus(0, 0, 1);
      if (kind == 0) begin
        applyStimulus(1, 0, len / 4 + 1);
        applyStimulus(1, 1, 2);
      end else if (kind < 5) begin
        applyStimulus(1, 0, len);
      end else begin
        applyStimulus(0, 1, len);
      end
      applyStimulus(0, 0, $urandom_range(1, 3));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
